// File: rtl/trdb_packet_scheduler.sv
// Trace packet scheduler: collects branch outcomes of retired instructions into
// branch-map / address / sync packets. Define TRDB_RESYNC_EN for periodic sync packets.
module trdb_packet_scheduler #(
    parameter int BMAP_LEN      = 31,
    parameter int RESYNC_CYCLES = 256
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                trace_enable_i,
    input  logic                valid_i,
    input  logic                branch_i,
    input  logic                branch_taken_i,
    input  logic                updiscon_i,
    input  logic                exception_i,
    output logic                stall_o,
    output logic                pkt_valid_o,
    input  logic                pkt_ready_i,
    output logic [1:0]          pkt_format_o,
    output logic [4:0]          pkt_branches_o,
    output logic [BMAP_LEN-1:0] pkt_branch_map_o
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_FLUSH = 2'd3;

    localparam logic [1:0] FMT_BMAP = 2'd1;
    localparam logic [1:0] FMT_ADDR = 2'd2;
    localparam logic [1:0] FMT_SYNC = 2'd3;

    localparam logic [4:0] BMAP_FULL = 5'(BMAP_LEN);

    logic [1:0]          state_q, state_d;
    logic                en_q;
    logic [4:0]          count_q, count_d;
    logic [BMAP_LEN-1:0] map_q, map_d;
    logic                pkt_valid_q, pkt_valid_d;
    logic [1:0]          fmt_q, fmt_d;
    logic [4:0]          br_q, br_d;
    logic [BMAP_LEN-1:0] pmap_q, pmap_d;

    logic                consume_s;
    logic                rise_s;
    logic                resync_due_s;
    logic                emit_s;
    logic [1:0]          emit_fmt_s;
    logic [4:0]          emit_cnt_s;
    logic [4:0]          cnt_upd_s;
    logic [BMAP_LEN-1:0] emit_map_s;
    logic [BMAP_LEN-1:0] map_upd_s;
    logic [BMAP_LEN-1:0] bit_s;

    // A pending resync turns any non-exception emit into a sync packet.
    function automatic logic [1:0] sync_or(input logic due, input logic [1:0] fmt);
        return due ? FMT_SYNC : fmt;
    endfunction

    assign rise_s    = trace_enable_i & ~en_q;
    assign consume_s = valid_i & ~pkt_valid_q & ((state_q == ST_START) | (state_q == ST_RUN));
    assign stall_o   = valid_i & pkt_valid_q;

    assign pkt_valid_o      = pkt_valid_q;
    assign pkt_format_o     = fmt_q;
    assign pkt_branches_o   = br_q;
    assign pkt_branch_map_o = pmap_q;

    // FSM, branch-map accumulation and emit decision.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        map_d      = map_q;
        emit_s     = 1'b0;
        emit_fmt_s = FMT_SYNC;
        emit_cnt_s = 5'd0;
        emit_map_s = {BMAP_LEN{1'b0}};
        bit_s      = {{(BMAP_LEN-1){1'b0}}, ~branch_taken_i} << count_q;
        cnt_upd_s  = count_q + {4'd0, branch_i};
        map_upd_s  = branch_i ? (map_q | bit_s) : map_q;
        case (state_q)
            ST_IDLE: begin
                if (rise_s) state_d = ST_START;
                else        state_d = ST_IDLE;
            end
            ST_START: begin
                if (consume_s) begin
                    emit_s  = 1'b1;
                    state_d = trace_enable_i ? ST_RUN : ST_FLUSH;
                end else if (!trace_enable_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_RUN: begin
                if (consume_s) begin
                    count_d    = cnt_upd_s;
                    map_d      = map_upd_s;
                    emit_cnt_s = cnt_upd_s;
                    emit_map_s = map_upd_s;
                    if (exception_i) begin
                        emit_s     = 1'b1;
                        emit_fmt_s = FMT_SYNC;
                    end else if (updiscon_i) begin
                        emit_s     = 1'b1;
                        emit_fmt_s = sync_or(resync_due_s,
                                             (cnt_upd_s == 5'd0) ? FMT_ADDR : FMT_BMAP);
                    end else if (cnt_upd_s == BMAP_FULL) begin
                        emit_s     = 1'b1;
                        emit_fmt_s = sync_or(resync_due_s, FMT_BMAP);
                    end else if (resync_due_s) begin
                        emit_s     = 1'b1;
                        emit_fmt_s = FMT_SYNC;
                    end else begin
                        emit_s     = 1'b0;
                    end
                end else begin
                    emit_s = 1'b0;
                end
                // The instruction of this cycle is already folded in before flushing.
                if (!trace_enable_i) state_d = ST_FLUSH;
                else                 state_d = ST_RUN;
            end
            ST_FLUSH: begin
                if (count_q != 5'd0) begin
                    if (!pkt_valid_q) begin
                        emit_s     = 1'b1;
                        emit_fmt_s = FMT_BMAP;
                        emit_cnt_s = count_q;
                        emit_map_s = map_q;
                    end else begin
                        emit_s = 1'b0;
                    end
                    state_d = ST_FLUSH;
                end else if (!pkt_valid_q || pkt_ready_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (emit_s) begin
            count_d = 5'd0;
            map_d   = {BMAP_LEN{1'b0}};
        end else begin
            count_d = count_d;
        end
    end

    // Output packet register: loaded on emit, released on handshake.
    always_comb begin
        pkt_valid_d = pkt_valid_q;
        fmt_d       = fmt_q;
        br_d        = br_q;
        pmap_d      = pmap_q;
        if (emit_s) begin
            pkt_valid_d = 1'b1;
            fmt_d       = emit_fmt_s;
            br_d        = emit_cnt_s;
            pmap_d      = emit_map_s;
        end else if (pkt_valid_q && pkt_ready_i) begin
            pkt_valid_d = 1'b0;
        end else begin
            pkt_valid_d = pkt_valid_q;
        end
    end

    // State and packet registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            en_q        <= 1'b0;
            count_q     <= 5'd0;
            map_q       <= {BMAP_LEN{1'b0}};
            pkt_valid_q <= 1'b0;
            fmt_q       <= 2'd0;
            br_q        <= 5'd0;
            pmap_q      <= {BMAP_LEN{1'b0}};
        end else begin
            state_q     <= state_d;
            en_q        <= trace_enable_i;
            count_q     <= count_d;
            map_q       <= map_d;
            pkt_valid_q <= pkt_valid_d;
            fmt_q       <= fmt_d;
            br_q        <= br_d;
            pmap_q      <= pmap_d;
        end
    end

`ifdef TRDB_RESYNC_EN
    localparam int RW = (RESYNC_CYCLES > 1) ? $clog2(RESYNC_CYCLES) : 1;
    localparam logic [RW-1:0] RESYNC_LAST = RW'(RESYNC_CYCLES - 1);

    logic [RW-1:0] resync_q, resync_d;

    assign resync_due_s = (resync_q == RESYNC_LAST);

    // Resync counter: counts RUN instructions, restarts on every sync packet.
    always_comb begin
        resync_d = resync_q;
        if (emit_s && (emit_fmt_s == FMT_SYNC)) begin
            resync_d = {RW{1'b0}};
        end else if (consume_s && (state_q == ST_RUN)) begin
            resync_d = resync_q + RW'(1);
        end else begin
            resync_d = resync_q;
        end
    end

    // Resync counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resync_q <= {RW{1'b0}};
        end else begin
            resync_q <= resync_d;
        end
    end
`else
    logic resync_unused_s;
    assign resync_due_s    = 1'b0;
    assign resync_unused_s = |RESYNC_CYCLES;
`endif

endmodule

// File: tb/tb_trdb_packet_scheduler.sv
// Scoreboard bench for trdb_packet_scheduler: stimulus pushes expected packets,
// a negedge monitor pops and compares on every output handshake.
module tb_trdb_packet_scheduler;
    typedef struct packed {
        logic [1:0]  fmt;
        logic [4:0]  br;
        logic [30:0] map;
    } pkt_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        trace_enable = 1'b0;
    logic        valid = 1'b0;
    logic        branch = 1'b0;
    logic        taken = 1'b0;
    logic        updiscon = 1'b0;
    logic        exception = 1'b0;
    logic        pkt_ready = 1'b1;
    logic        stall;
    logic        pkt_valid;
    logic [1:0]  fmt;
    logic [4:0]  br;
    logic [30:0] bmap;

    pkt_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    trdb_packet_scheduler #(.BMAP_LEN(31), .RESYNC_CYCLES(256)) dut (
        .clk_i(clk), .rst_ni(rst_n), .trace_enable_i(trace_enable), .valid_i(valid),
        .branch_i(branch), .branch_taken_i(taken), .updiscon_i(updiscon),
        .exception_i(exception), .stall_o(stall), .pkt_valid_o(pkt_valid),
        .pkt_ready_i(pkt_ready), .pkt_format_o(fmt), .pkt_branches_o(br),
        .pkt_branch_map_o(bmap)
    );

`ifdef TRDB_RESYNC_EN
    logic        rs_stall;
    logic        rs_valid;
    logic [1:0]  rs_fmt;
    logic [4:0]  rs_br;
    logic [30:0] rs_map;

    trdb_packet_scheduler #(.BMAP_LEN(31), .RESYNC_CYCLES(8)) dut_rs (
        .clk_i(clk), .rst_ni(rst_n), .trace_enable_i(trace_enable), .valid_i(valid),
        .branch_i(branch), .branch_taken_i(taken), .updiscon_i(updiscon),
        .exception_i(exception), .stall_o(rs_stall), .pkt_valid_o(rs_valid),
        .pkt_ready_i(pkt_ready), .pkt_format_o(rs_fmt), .pkt_branches_o(rs_br),
        .pkt_branch_map_o(rs_map)
    );
`endif

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Present one instruction and hold it until it is consumed.
    task automatic send(input logic b, input logic t, input logic u, input logic e);
        int n = 0;
        @(posedge clk); #1;
        valid = 1'b1; branch = b; taken = t; updiscon = u; exception = e;
        @(negedge clk);
        while (stall && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: stall_o stuck at 1 for %0d cycles, expected 0", n);
        end
        @(posedge clk); #1;
        valid = 1'b0; branch = 1'b0; taken = 1'b0; updiscon = 1'b0; exception = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk); #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d packets still pending, expected 0", name, sb_q.size());
        end
    endtask

    // Monitor: every accepted packet must match the oldest expected one.
    always @(negedge clk) begin
        pkt_t got;
        pkt_t exp;
        if (rst_n && pkt_valid && pkt_ready) begin
            got = {fmt, br, bmap};
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pkt: got fmt=%0d br=%0d map=0x%0h, expected none",
                         fmt, br, bmap);
            end else begin
                exp = sb_q.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL pkt: got fmt=%0d br=%0d map=0x%0h, expected fmt=%0d br=%0d map=0x%0h",
                             got.fmt, got.br, got.map, exp.fmt, exp.br, exp.map);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pkt_valid", {31'd0, pkt_valid}, 32'd0);
        check("rst_fmt", {30'd0, fmt}, 32'd0);
        check("rst_br", {27'd0, br}, 32'd0);
        check("rst_map", {1'b0, bmap}, 32'd0);
        check("rst_state", {30'd0, dut.state_q}, 32'd0);
        rst_n = 1'b1;

        // Enable, then one plain instruction gives a sync packet.
        @(posedge clk); #1;
        trace_enable = 1'b1;
        sb_q.push_back({2'd3, 5'd0, 31'd0});
        send(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("run_state", {30'd0, dut.state_q}, 32'd2);

        // 31 alternating branches, taken first, fill the map.
        for (int k = 0; k < 31; k++) begin
            if (k == 30) sb_q.push_back({2'd1, 5'd31, 31'h2AAAAAAA});
            send(1'b1, (k % 2) == 0, 1'b0, 1'b0);
        end

        // T, NT, T then updiscon; then updiscon with an empty map.
        sb_q.push_back({2'd1, 5'd3, 31'b010});
        send(1'b1, 1'b1, 1'b0, 1'b0);
        send(1'b1, 1'b0, 1'b0, 1'b0);
        send(1'b1, 1'b1, 1'b0, 1'b0);
        send(1'b0, 1'b0, 1'b1, 1'b0);
        sb_q.push_back({2'd2, 5'd0, 31'd0});
        send(1'b0, 1'b0, 1'b1, 1'b0);
        wait_drain("drain_updiscon");

        // Back-pressure: packet held, next instruction stalls but is not lost.
        pkt_ready = 1'b0;
        sb_q.push_back({2'd3, 5'd0, 31'd0});
        send(1'b0, 1'b0, 1'b0, 1'b1);
        valid = 1'b1; branch = 1'b1; taken = 1'b0; updiscon = 1'b1;
        sb_q.push_back({2'd1, 5'd1, 31'd1});
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_stall", {31'd0, stall}, 32'd1);
            check("bp_valid", {31'd0, pkt_valid}, 32'd1);
            check("bp_fmt", {30'd0, fmt}, 32'd3);
            check("bp_br", {27'd0, br}, 32'd0);
            check("bp_map", {1'b0, bmap}, 32'd0);
        end
        @(posedge clk); #1;
        pkt_ready = 1'b1;
        send(1'b1, 1'b0, 1'b1, 1'b0);

        // Two pending branches, then disable: flush packet then IDLE.
        send(1'b1, 1'b1, 1'b0, 1'b0);
        send(1'b1, 1'b0, 1'b0, 1'b0);
        trace_enable = 1'b0;
        sb_q.push_back({2'd1, 5'd2, 31'b10});
        n = 0;
        while (dut.state_q != 2'd0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("flush_idle", {30'd0, dut.state_q}, 32'd0);
        wait_drain("drain_flush");

`ifdef TRDB_RESYNC_EN
        n = 0;
        while (dut_rs.state_q != 2'd0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("rs_idle", {30'd0, dut_rs.state_q}, 32'd0);
        trace_enable = 1'b1;
        sb_q.push_back({2'd3, 5'd0, 31'd0});
        send(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            send(1'b0, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            check("rs_valid", {31'd0, rs_valid}, (i == 8) ? 32'd1 : 32'd0);
            if (i == 8) check("rs_fmt", {30'd0, rs_fmt}, 32'd3);
        end
        @(posedge clk); #1;
        trace_enable = 1'b0;
        repeat (4) @(posedge clk);
        #1;
`endif

        // Reset while a packet is held discards it.
        wait_drain("pre_reset");
        trace_enable = 1'b1;
        pkt_ready = 1'b0;
        send(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("held_before_reset", {31'd0, pkt_valid}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, pkt_valid}, 32'd0);
        check("mid_rst_fmt", {30'd0, fmt}, 32'd0);
        check("mid_rst_state", {30'd0, dut.state_q}, 32'd0);
        check("mid_rst_count", {27'd0, dut.count_q}, 32'd0);
        trace_enable = 1'b0;
        pkt_ready = 1'b1;
        valid = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("post_rst_quiet", {31'd0, pkt_valid}, 32'd0);
        end
        valid = 1'b0;

        wait_drain("final_drain");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
